// File: rtl/loteria_param_if.sv
// rtl/loteria_param_if.sv - board-side bus for the parametrised lottery block
interface loteria_param_if #(
    parameter int NUM_DIGITS = 5,
    parameter int DIGIT_W    = 4
);
    logic [DIGIT_W-1:0]            num;
    logic                          insert;
    logic                          finish;
    logic                          key_load;
    logic [NUM_DIGITS*DIGIT_W-1:0] key_in;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits;
    logic [3:0]                    entered;
    logic                          busy;
    logic                          done;
    logic                          win;
    logic [1:0]                    prize;
    logic [3:0]                    match_count;
    logic                          err_invalid;

    modport master (
        output num, insert, finish, key_load, key_in,
        input  digits, entered, busy, done, win, prize, match_count, err_invalid
    );

    modport slave (
        input  num, insert, finish, key_load, key_in,
        output digits, entered, busy, done, win, prize, match_count, err_invalid
    );
endinterface

// File: rtl/loteria_param.sv
// rtl/loteria_param.sv - lottery ticket entry, digit-serial key compare and prize tiering
module loteria_param #(
    parameter int NUM_DIGITS   = 5,
    parameter int DIGIT_W      = 4,
    parameter int MAX_DIGIT    = 9,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] KEY_DEFAULT = 20'h50967,
    parameter int P1_MATCH     = 4,
    parameter int P2_MATCH     = 3,
    parameter int P2_NEED_LAST = 1
) (
    input  logic           clk,
    input  logic           reset,
    loteria_param_if.slave bus
);
    localparam int KW = NUM_DIGITS * DIGIT_W;
    localparam logic [DIGIT_W-1:0] MAX_D   = DIGIT_W'(MAX_DIGIT);
    localparam logic [3:0]         N4      = 4'(NUM_DIGITS);
    localparam logic [2:0]         LAST_IX = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]         P1_4    = 4'(P1_MATCH);
    localparam logic [3:0]         P2_4    = 4'(P2_MATCH);

    typedef enum logic [1:0] {S_ENTRY, S_READY, S_CHECK, S_RESULT} state_t;

    state_t             state_q, state_d;
    logic [KW-1:0]      digits_q, digits_d;
    logic [KW-1:0]      key_q, key_d;
    logic [3:0]         entered_q, entered_d;
    logic [2:0]         idx_q, idx_d;
    logic [3:0]         acc_q, acc_d;
    logic               last_hit_q, last_hit_d;
    logic [3:0]         match_q, match_d;
    logic [1:0]         prize_q, prize_d;
    logic               err_q, err_d;
    logic               insert_q, finish_q, key_load_q;

    logic               ins_ev, fin_ev, kl_ev;
    logic [DIGIT_W-1:0] cur_digit, cur_key;
    logic               hit;
    logic [3:0]         final_cnt;
    logic [3:0]         entered_inc;
    logic [1:0]         tier;

    assign ins_ev = bus.insert   & ~insert_q;
    assign fin_ev = bus.finish   & ~finish_q;
    assign kl_ev  = bus.key_load & ~key_load_q;

    // Digit 0 lives in the most significant field of both entry and key.
    always_comb begin
        cur_digit = '0;
        cur_key   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_digit = digits_q[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
                cur_key   = key_q[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign hit         = (cur_digit == cur_key);
    assign final_cnt   = acc_q + {3'b000, hit};
    assign entered_inc = entered_q + 4'd1;

    // Tier is evaluated on the last compare cycle, using that cycle's hit as last_hit.
    always_comb begin
        tier = 2'd0;
        if (final_cnt == N4) begin
            tier = 2'd3;
        end else if (final_cnt >= P1_4) begin
            tier = 2'd1;
        end else if ((final_cnt >= P2_4) && (hit || (P2_NEED_LAST == 0))) begin
            tier = 2'd2;
        end
    end

    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        key_d      = key_q;
        entered_d  = entered_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        last_hit_d = last_hit_q;
        match_d    = match_q;
        prize_d    = prize_q;
        err_d      = 1'b0;

        case (state_q)
            S_ENTRY: begin
                if (kl_ev && (entered_q == 4'd0)) begin
                    key_d = bus.key_in;
                end
                if (ins_ev) begin
                    if (bus.num > MAX_D) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (entered_q == 4'(i)) begin
                                digits_d[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = bus.num;
                            end
                        end
                        entered_d = entered_inc;
                        if (entered_inc == N4) begin
                            state_d = S_READY;
                        end
                    end
                end
            end
            S_READY: begin
                if (fin_ev) begin
                    state_d    = S_CHECK;
                    idx_d      = 3'd0;
                    acc_d      = 4'd0;
                    last_hit_d = 1'b0;
                end
            end
            S_CHECK: begin
                acc_d = final_cnt;
                idx_d = idx_q + 3'd1;
                if (idx_q == LAST_IX) begin
                    last_hit_d = hit;
                    match_d    = final_cnt;
                    prize_d    = tier;
                    state_d    = S_RESULT;
                end
            end
            S_RESULT: begin
                if (ins_ev) begin
                    digits_d  = '0;
                    entered_d = 4'd0;
                    match_d   = 4'd0;
                    prize_d   = 2'd0;
                    state_d   = S_ENTRY;
                end
            end
            default: state_d = S_ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_ENTRY;
            digits_q   <= '0;
            key_q      <= KEY_DEFAULT;
            entered_q  <= 4'd0;
            idx_q      <= 3'd0;
            acc_q      <= 4'd0;
            last_hit_q <= 1'b0;
            match_q    <= 4'd0;
            prize_q    <= 2'd0;
            err_q      <= 1'b0;
            insert_q   <= 1'b0;
            finish_q   <= 1'b0;
            key_load_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            key_q      <= key_d;
            entered_q  <= entered_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            last_hit_q <= last_hit_d;
            match_q    <= match_d;
            prize_q    <= prize_d;
            err_q      <= err_d;
            insert_q   <= bus.insert;
            finish_q   <= bus.finish;
            key_load_q <= bus.key_load;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.entered     = entered_q;
    assign bus.busy        = (state_q == S_CHECK);
    assign bus.done        = (state_q == S_RESULT);
    assign bus.win         = (prize_q != 2'd0);
    assign bus.prize       = prize_q;
    assign bus.match_count = match_q;
    assign bus.err_invalid = err_q;
endmodule

// File: doc/loteria_param.md
Name: loteria_param

Overview:
- Parametrised successor of the five-digit lottery game FSM.
- The player enters NUM_DIGITS BCD digits one at a time, then presses finish.
- The block compares the entry against a secret key digit by digit, one digit per cycle, and reports the match count and a prize tier.
- Adds edge-detected buttons, invalid-digit rejection, a runtime-loadable key and a jackpot tier. It sits between the board buttons/switches and the 7-segment/LED display logic.

Parameters:
- NUM_DIGITS, 5, number of digits per ticket (2..8).
- DIGIT_W, 4, bits per digit; values above MAX_DIGIT are rejected.
- MAX_DIGIT, 9, largest legal digit value.
- KEY_DEFAULT, 20'h50967, reset value of the secret key. Digit 0 sits in the MS nibble; width is NUM_DIGITS*DIGIT_W.
- P1_MATCH, 4, minimum matches for prize 1.
- P2_MATCH, 3, minimum matches for prize 2.
- P2_NEED_LAST, 1, if 1, prize 2 also requires the last digit to match.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- num  in  DIGIT_W  digit on switches.
- insert  in  1  level button; acts on its rising edge.
- finish  in  1  level button; acts on its rising edge.
- key_load  in  1  level; rising edge loads key_in.
- key_in  in  NUM_DIGITS*DIGIT_W  new secret key.
- digits  out  NUM_DIGITS*DIGIT_W  entered digits; digit 0 in the MS field.
- entered  out  4  number of digits accepted so far.
- busy  out  1  high while in CHECK.
- done  out  1  high while in RESULT.
- win  out  1  prize != 0.
- prize  out  2  0 none, 1 prize 1, 2 prize 2, 3 jackpot.
- match_count  out  4  matching digits, valid while done.
- err_invalid  out  1  one-cycle pulse when a digit is rejected.

Behaviour:
- Reset (synchronous, reset=1 at a posedge): state=ENTRY, digits=0, entered=0, busy=0, done=0, win=0, prize=0, match_count=0, err_invalid=0, key=KEY_DEFAULT, edge-detect registers cleared.
  - Reset overrides everything, including mid-CHECK.
  - The key reloads to KEY_DEFAULT on reset.
- Edge detect: each button has a previous-value register. An event is defined as btn & ~btn_q. Holding a button produces exactly one event.
- ENTRY:
  - On an insert event with num <= MAX_DIGIT: digit[entered] <= num and entered++.
  - When entered reaches NUM_DIGITS, go to READY.
  - On an insert event with num > MAX_DIGIT: digit is not stored, entered unchanged, err_invalid pulses for 1 cycle.
  - A finish event in ENTRY is ignored.
  - A key_load event is accepted only when entered==0. Otherwise it is ignored.
- READY:
  - Insert events are ignored.
  - A finish event goes to CHECK, clears the match accumulator and sets the index to 0.
- CHECK:
  - Each cycle, compare digit[idx] with key[idx]; increment the accumulator on equality. Record last_hit when idx==NUM_DIGITS-1.
  - After NUM_DIGITS cycles go to RESULT. Latency from the finish event cycle to done=1 is NUM_DIGITS+1 cycles.
  - busy=1 throughout. All buttons are ignored.
- RESULT: match_count is loaded on entry, then prize is evaluated in this priority order:
  - matches==NUM_DIGITS gives 3.
  - matches>=P1_MATCH gives 1.
  - matches>=P2_MATCH && (last_hit || !P2_NEED_LAST) gives 2.
  - Otherwise 0.
  - win = (prize != 0).
  - done=1 and outputs hold. An insert event clears the digits, entered, prize, win and match_count, then returns to ENTRY and stores nothing from that event.
- Simultaneous insert and finish events: insert takes priority in ENTRY; finish takes priority in READY.
- The key register is never visible on outputs.

Test Plan:
- Entry 5,0,9,6,7, then finish -> done exactly 6 cycles after the finish edge; match_count=5, prize=3, win=1.
- Entry 5,0,9,6,1 -> match_count=4, prize=1, win=1.
- Entry 1,1,9,6,7 -> match_count=3 with last digit hit, prize=2.
- Entry 5,0,9,1,1 -> match_count=3 with last digit missed, prize=0, win=0.
- Hold insert high for 10 cycles with num=3 -> entered=1 only. Then insert num=12 -> err_invalid pulses once and entered stays 1.
- key_load with key_in=20'h12345 at entered=0, then entry 1,2,3,4,5 -> prize=3.
  - Assert reset during CHECK -> all outputs return to reset values the next cycle.
  - After that reset, the key is 50967 again.
